// File: rtl/rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_pkg
// Description : Shared round-robin types: FSM encoding, default slice sizing
//               and a one-hot to binary helper used by scheduler and consumer.
// Revision    : 1.0  initial release
// ============================================================================
package rr_pkg;

    localparam int DEF_GSIZE     = 4;
    localparam int DEF_LOG_GSIZE = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    function automatic logic [DEF_LOG_GSIZE-1:0] onehot_to_bin(
        input logic [DEF_GSIZE-1:0] onehot
    );
        logic [DEF_LOG_GSIZE-1:0] bin;
        bin = '0;
        for (int i = 0; i < DEF_GSIZE; i++) begin
            if (onehot[i]) bin = bin | DEF_LOG_GSIZE'(i);
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_onehot_enc.sv
`default_nettype none
// ============================================================================
// Module      : rr_onehot_enc
// Description : One-hot to binary encoder with any-set and multi-hot flags.
// Revision    : 1.0  initial release
// ============================================================================
import rr_pkg::*;

module rr_onehot_enc #(
    parameter int GSIZE     = DEF_GSIZE,
    parameter int LOG_GSIZE = DEF_LOG_GSIZE
) (
    input  logic [GSIZE-1:0]     i_onehot,
    output logic [LOG_GSIZE-1:0] o_bin,
    output logic                 o_any,
    output logic                 o_multi
);

    logic w_seen;
    logic w_multi;

    // Each binary bit is the OR of the one-hot lines whose index has that bit set.
    for (genvar b = 0; b < LOG_GSIZE; b++) begin : g_bin_bit
        logic [GSIZE-1:0] w_mask;
        for (genvar i = 0; i < GSIZE; i++) begin : g_mask
            assign w_mask[i] = 1'((i >> b) & 1);
        end
        assign o_bin[b] = |(i_onehot & w_mask);
    end

    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < GSIZE; i++) begin
            if (i_onehot[i]) begin
                w_multi = w_multi | w_seen;
                w_seen  = 1'b1;
            end
        end
    end

    assign o_any   = w_seen;
    assign o_multi = w_multi;

endmodule
`default_nettype wire

// File: rtl/rr_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rr_xfer_ctrl
// Description : Turns one scheduler slice grant into a packet transfer and
//               stalls the slice while the packet is in flight.
//               Optional idle watchdog: define RR_XFER_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
import rr_pkg::*;

module rr_xfer_ctrl #(
    parameter int GSIZE         = DEF_GSIZE,
    parameter int LOG_GSIZE     = DEF_LOG_GSIZE,
    parameter int MAX_BEATS     = 64,
    parameter int LOG_MAX_BEATS = 6
`ifdef RR_XFER_TIMEOUT_EN
    ,
    parameter int TIMEOUT       = 255
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [GSIZE-1:0]     grant,
    input  logic [GSIZE-1:0]     src_valid,
    input  logic [GSIZE-1:0]     src_last,
    input  logic                 dst_ready,
    output logic                 stall,
    output logic [LOG_GSIZE-1:0] sel,
    output logic [GSIZE-1:0]     src_pop,
    output logic                 dst_valid,
    output logic                 busy,
    output logic                 grant_err
`ifdef RR_XFER_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    localparam logic [LOG_MAX_BEATS:0] c_max_beats = (LOG_MAX_BEATS+1)'(MAX_BEATS);
    localparam logic [LOG_MAX_BEATS:0] c_cnt_one   = (LOG_MAX_BEATS+1)'(1);

    logic [1:0]             r_state;
    logic [LOG_GSIZE-1:0]   r_sel;
    logic [LOG_MAX_BEATS:0] r_beat_cnt;
    logic                   r_grant_err;
    logic [LOG_GSIZE-1:0]   w_grant_bin;
    logic                   w_grant_any;
    logic                   w_grant_multi;
    logic                   w_in_xfer;
    logic                   w_beat;
    logic [LOG_MAX_BEATS:0] w_cnt_inc;

    rr_onehot_enc #(
        .GSIZE     (GSIZE),
        .LOG_GSIZE (LOG_GSIZE)
    ) u_grant_enc (
        .i_onehot (grant),
        .o_bin    (w_grant_bin),
        .o_any    (w_grant_any),
        .o_multi  (w_grant_multi)
    );

    assign w_in_xfer = (r_state == ST_XFER);
    assign w_beat    = w_in_xfer & src_valid[r_sel] & dst_ready;
    assign w_cnt_inc = r_beat_cnt + c_cnt_one;

    // Zero-latency datapath controls: the beat completes in the cycle it is seen.
    assign stall     = w_in_xfer;
    assign busy      = w_in_xfer;
    assign dst_valid = w_beat;
    assign src_pop   = w_beat ? (GSIZE'(1) << r_sel) : '0;
    assign sel       = r_sel;
    assign grant_err = r_grant_err;

`ifdef RR_XFER_TIMEOUT_EN
    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    logic [7:0] r_idle_cnt;
    logic       r_timeout_err;

    assign timeout_err = r_timeout_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_beat_cnt  <= '0;
            r_grant_err <= 1'b0;
`ifdef RR_XFER_TIMEOUT_EN
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_grant_err <= 1'b0;
`ifdef RR_XFER_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            if (clr) begin
                r_state    <= ST_IDLE;
                r_beat_cnt <= '0;
`ifdef RR_XFER_TIMEOUT_EN
                r_idle_cnt <= '0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_grant_multi) begin
                            r_grant_err <= 1'b1;
                        end else if (w_grant_any) begin
                            r_sel      <= w_grant_bin;
                            r_beat_cnt <= '0;
                            r_state    <= ST_XFER;
`ifdef RR_XFER_TIMEOUT_EN
                            r_idle_cnt <= '0;
`endif
                        end
                    end
                    ST_XFER: begin
                        if (w_beat) begin
                            r_beat_cnt <= w_cnt_inc;
                            // End of packet or forced release share one exit.
                            if (src_last[r_sel] || (w_cnt_inc == c_max_beats)) begin
                                r_state <= ST_GAP;
                            end
`ifdef RR_XFER_TIMEOUT_EN
                            r_idle_cnt <= '0;
                        end else if ((r_idle_cnt + 8'd1) == c_timeout) begin
                            r_idle_cnt    <= '0;
                            r_timeout_err <= 1'b1;
                            r_state       <= ST_GAP;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 8'd1;
`endif
                        end
                    end
                    ST_GAP:  r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_xfer_ctrl
// Description : Self-checking bench for rr_xfer_ctrl against a session-level
//               model of per-input packet queues and grant sessions.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rr_xfer_ctrl;

    localparam int MAXB = 4;
    localparam int TOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] grant = '0;
    logic [3:0] src_valid = '0;
    logic [3:0] src_last = '0;
    logic       dst_ready = 1'b0;
    logic       stall;
    logic [1:0] sel;
    logic [3:0] src_pop;
    logic       dst_valid;
    logic       busy;
    logic       grant_err;
`ifdef RR_XFER_TIMEOUT_EN
    logic       timeout_err;
`endif

    rr_xfer_ctrl #(
        .GSIZE         (4),
        .LOG_GSIZE     (2),
        .MAX_BEATS     (MAXB),
        .LOG_MAX_BEATS (2)
`ifdef RR_XFER_TIMEOUT_EN
        ,
        .TIMEOUT       (TOUT)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .grant     (grant),
        .src_valid (src_valid),
        .src_last  (src_last),
        .dst_ready (dst_ready),
        .stall     (stall),
        .sel       (sel),
        .src_pop   (src_pop),
        .dst_valid (dst_valid),
        .busy      (busy),
        .grant_err (grant_err)
`ifdef RR_XFER_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: beats left in each source queue plus the current grant session.
    int  rem [4];
    int  pop_cnt [4];
    int  tout_cnt = 0;
    bit  m_active = 0;
    bit  m_gap    = 0;
    int  m_owner  = 0;
    int  m_quota  = 0;
    int  m_idle   = 0;
    bit  m_err    = 0;
    bit  m_tout   = 0;
    logic [1:0] m_sel = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] g, input logic [3:0] vm, input logic dr, input logic c);
        logic       e_beat;
        logic [3:0] e_pop;
        @(negedge clk);
        grant     = g;
        dst_ready = dr;
        clr       = c;
        for (int i = 0; i < 4; i++) begin
            src_valid[i] = vm[i] && (rem[i] > 0);
            src_last[i]  = (rem[i] == 1);
        end
        #1;
        e_beat = m_active && src_valid[m_owner] && dst_ready;
        e_pop  = e_beat ? 4'(1 << m_owner) : 4'b0000;
        check("outs", {24'd0, stall, busy, dst_valid, grant_err, src_pop},
                      {24'd0, m_active, m_active, e_beat, m_err, e_pop});
        check("sel", {30'd0, sel}, {30'd0, m_sel});
`ifdef RR_XFER_TIMEOUT_EN
        check("tout", {31'd0, timeout_err}, {31'd0, m_tout});
        tout_cnt += int'(timeout_err);
`endif
        for (int i = 0; i < 4; i++) pop_cnt[i] += int'(src_pop[i]);
        @(posedge clk);
        m_err  = 0;
        m_tout = 0;
        if (e_beat) rem[m_owner]--;
        if (c) begin
            m_active = 0;
            m_gap    = 0;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (m_active) begin
            if (e_beat) begin
                m_quota--;
                m_idle = 0;
                if (m_quota == 0) begin
                    m_active = 0;
                    m_gap    = 1;
                end
            end
`ifdef RR_XFER_TIMEOUT_EN
            else begin
                m_idle++;
                if (m_idle == TOUT) begin
                    m_active = 0;
                    m_gap    = 1;
                    m_tout   = 1;
                end
            end
`endif
        end else if ($countones(g) > 1) begin
            m_err = 1;
        end else if (g != 4'b0000) begin
            for (int i = 0; i < 4; i++) if (g[i]) m_owner = i;
            m_sel    = 2'(m_owner);
            m_active = 1;
            m_idle   = 0;
            m_quota  = (rem[m_owner] < MAXB) ? rem[m_owner] : MAXB;
        end
    endtask

    initial begin
        int exp_sess [3];
        exp_sess = '{4, 4, 2};
        for (int i = 0; i < 4; i++) begin
            rem[i]     = 0;
            pop_cnt[i] = 0;
        end

        // Reset state
        #2;
        check("rst_outs", {24'd0, stall, busy, dst_valid, grant_err, src_pop}, 32'd0);
        check("rst_sel", {30'd0, sel}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single packet of 3 beats on input 2
        rem[2] = 3;
        step(4'b0100, 4'hF, 1'b1, 1'b0);
        repeat (5) step(4'b0000, 4'hF, 1'b1, 1'b0);
        check("pkt_pops", pop_cnt[2], 3);

        // Backpressure on the same packet shape
        rem[2] = 3;
        pop_cnt[2] = 0;
        step(4'b0100, 4'hF, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) step(4'b0000, 4'hF, (k % 2) == 0, 1'b0);
        repeat (2) step(4'b0000, 4'hF, 1'b1, 1'b0);
        check("bp_pops", pop_cnt[2], 3);

        // Forced release: 10-beat packet, MAX_BEATS per grant
        rem[1] = 10;
        for (int s = 0; s < 3; s++) begin
            pop_cnt[1] = 0;
            step(4'b0010, 4'hF, 1'b1, 1'b0);
            repeat (6) step(4'b0000, 4'hF, 1'b1, 1'b0);
            check("release_pops", pop_cnt[1], exp_sess[s]);
        end

        // Multi-hot grant in IDLE
        step(4'b0110, 4'hF, 1'b1, 1'b0);
        step(4'b0000, 4'hF, 1'b1, 1'b0);
        step(4'b0000, 4'hF, 1'b1, 1'b0);

        // clr at beat 2
        rem[0] = 6;
        pop_cnt[0] = 0;
        step(4'b0001, 4'hF, 1'b1, 1'b0);
        step(4'b0000, 4'hF, 1'b1, 1'b0);
        step(4'b0000, 4'hF, 1'b1, 1'b1);
        repeat (3) step(4'b0000, 4'hF, 1'b1, 1'b0);
        check("clr_pops", pop_cnt[0], 2);

        // Asynchronous reset during a beat
        rem[3] = 5;
        step(4'b1000, 4'hF, 1'b1, 1'b0);
        step(4'b0000, 4'hF, 1'b1, 1'b0);
        step(4'b0000, 4'hF, 1'b1, 1'b0);
        @(negedge clk);
        grant = '0; clr = 1'b0; dst_ready = 1'b1;
        src_valid = 4'b1000; src_last = 4'b0000;
        #1;
        check("pre_rst_pop", {28'd0, src_pop}, 32'h8);
        rst = 1'b1;
        #1;
        check("rst_mid_pop", {28'd0, src_pop}, 32'd0);
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_sel", {30'd0, sel}, 32'd0);
        m_active = 0; m_gap = 0; m_err = 0; m_tout = 0; m_sel = '0;
        @(negedge clk);
        rst = 1'b0;

`ifdef RR_XFER_TIMEOUT_EN
        // Watchdog: granted source never becomes valid
        rem[0] = 3;
        tout_cnt = 0;
        step(4'b0001, 4'h0, 1'b1, 1'b0);
        repeat (TOUT + 3) step(4'b0000, 4'h0, 1'b1, 1'b0);
        check("tout_pulses", tout_cnt, 1);
`endif

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            logic [3:0] g;
            int         r;
            int         j;
            if (!m_active && !m_gap) begin
                for (int i = 0; i < 4; i++)
                    if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 10);
                r = $urandom_range(0, 9);
                g = 4'b0000;
                if (r == 0) begin
                    g = 4'(4'b0011 << $urandom_range(0, 2));
                end else if (r >= 3) begin
                    j = $urandom_range(0, 3);
                    for (int t = 0; t < 4; t++)
                        if (g == 4'b0000 && rem[(j + t) % 4] > 0) g = 4'(1 << ((j + t) % 4));
                end
            end else begin
                g = 4'($urandom);
            end
            step(g, 4'($urandom) | 4'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_xfer_ctrl.md
Name: rr_xfer_ctrl

Overview:
- Downstream consumer of one round-robin scheduler slice: takes the one-hot grant of a single slice and turns it into a packet transfer from the granted input to its output port.
- Drives crossbar mux select, source FIFO pop strobes and destination valid.
- Returns stall to the scheduler slice, which holds its grant stable while a packet is in flight.
- Sixteen instances sit beside the 16-slice scheduler, one per slice.

Parameters:
- GSIZE, 4, number of competing inputs per slice (grant width).
- LOG_GSIZE, 2, log2(GSIZE), select width.
- MAX_BEATS, 64, maximum beats per transfer before forced release (>=1).
- LOG_MAX_BEATS, 6, beat counter width; counter is LOG_MAX_BEATS+1 bits.
- TIMEOUT, 255, idle-beat watchdog limit (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear, returns the FSM to IDLE.
- grant  in  GSIZE  one-hot grant from the scheduler slice; all-zero means no grant.
- src_valid  in  GSIZE  per-input data-available flag (source FIFO not empty).
- src_last  in  GSIZE  per-input end-of-packet flag on the current head beat.
- dst_ready  in  1  output port can accept a beat this cycle.
- stall  out  1  to the scheduler; holds the current grant.
- sel  out  LOG_GSIZE  binary crossbar select.
- src_pop  out  GSIZE  one-hot pop strobe to the granted source FIFO.
- dst_valid  out  1  beat presented on the crossbar output this cycle.
- busy  out  1  high in XFER.
- grant_err  out  1  one-cycle pulse: multi-hot grant sampled in IDLE.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, sel=0, beat_cnt=0, stall=0, busy=0, grant_err=0.
- Reset forces the outputs that depend on state to zero: src_pop=0, dst_valid=0.
- States are IDLE, XFER and GAP.
- IDLE:
  - stall=0.
  - When grant is exactly one-hot: register sel=index(grant), clear beat_cnt, go to XFER next cycle.
  - Grant all-zero: stay in IDLE.
  - Grant multi-hot: stay in IDLE, pulse grant_err for one cycle, sel unchanged.
- XFER:
  - stall=1 and busy=1, both combinational from state.
  - beat = src_valid[sel] & dst_ready.
  - src_pop[sel]=beat, other src_pop bits 0; dst_valid=beat. Both combinational, zero latency.
  - Each beat increments beat_cnt.
  - Exit to GAP after a beat when src_last[sel]=1, or when beat_cnt+1 == MAX_BEATS (forced release; the remainder of the packet waits for the next grant).
  - Both exit conditions in the same cycle: single transition to GAP, no double count.
  - No beat (src_valid low or dst_ready low): hold state, counter unchanged.
- GAP:
  - Exactly one cycle, stall=0, no pops.
  - Lets the scheduler advance its pointer.
  - Always goes to IDLE. Grant is not sampled in GAP, so the new grant is seen in IDLE on the following cycle.
- clr:
  - Any state to IDLE next cycle, beat_cnt=0; sel holds its value.
  - A beat asserted in the clr cycle still completes, because outputs are combinational.
  - clr has priority over every transition.
- Grant changes while in XFER are ignored; sel is latched.
- Reset mid-XFER: outputs drop immediately, no pop after rst is asserted; the in-flight packet is truncated.
- Throughput: one beat per cycle in XFER. Arbitration overhead is 2 cycles per packet (IDLE sample and GAP).

Optional Feature:
- Macro: RR_XFER_TIMEOUT_EN.
- Defined:
  - An idle counter (8 bits) clears on every beat and increments on every non-beat cycle in XFER.
  - When it reaches TIMEOUT: go to GAP and pulse output timeout_err (1 bit, extra port present only under the macro) for one cycle.
  - The counter resets on rst, on clr, and on entry to XFER.
- Undefined: no counter and no timeout_err port; XFER waits indefinitely for src_valid and dst_ready.

Decomposition:
- Package rr_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_XFER=2'd1, ST_GAP=2'd2;
  - default GSIZE/LOG_GSIZE;
  - an onehot-to-binary function shared with the scheduler.
- One natural sub-module: rr_onehot_enc (GSIZE one-hot to LOG_GSIZE binary plus a multi-hot flag), instantiated once for grant sampling.

Test Plan:
- Single packet: grant=4'b0100, src_valid[2]=1, dst_ready=1, src_last on beat 3.
  - sel=2 one cycle after grant.
  - src_pop=4'b0100 for 3 cycles, then GAP with stall=0, then IDLE.
- Backpressure: same packet with dst_ready toggling 1,0,1,0.
  - Pops only on dst_ready=1 cycles, beat_cnt counts 3 beats total, stall held throughout.
- Forced release: MAX_BEATS=4, packet of 10 beats.
  - Release to GAP after beat 4; the next grant to the same input resumes, 4 more beats.
- Multi-hot grant: grant=4'b0110 in IDLE.
  - grant_err=1 for one cycle, no transition, src_pop=0.
- clr and rst mid-XFER at beat 2:
  - clr: IDLE next cycle, no further pops.
  - rst: pops and stall drop asynchronously in the same cycle.
- With RR_XFER_TIMEOUT_EN, TIMEOUT=8, src_valid held low after grant:
  - timeout_err pulses after 8 idle XFER cycles, then GAP, then IDLE.
